// File: rtl/play_audio_pkg.sv
// Shared types and default constants for the play_audio tone generator.
package play_audio_pkg;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } phase_t;

    localparam int DEF_DATA_W            = 24;
    localparam int DEF_WINDOW            = 12500000;
    localparam int DEF_HALF_PERIOD       = 454545;
    localparam int DEF_AMPLITUDE         = 4000000;
    localparam int DEF_GHOST_HALF_PERIOD = 113636;

endpackage

// File: rtl/play_audio_tone_osc.sv
// Free-running square-wave oscillator: each phase lasts HALF_PERIOD cycles and
// the output sample is +AMPLITUDE in POS and -AMPLITUDE in NEG.
module tone_osc
    import play_audio_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int AMPLITUDE   = DEF_AMPLITUDE
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic signed [DATA_W-1:0] sample_o
);

    localparam int HP_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HP_W-1:0]          HP_LAST = HP_W'(HALF_PERIOD - 1);
    localparam logic signed [DATA_W-1:0] AMP_POS = DATA_W'(AMPLITUDE);
    localparam logic signed [DATA_W-1:0] AMP_NEG = -AMP_POS;

    logic [HP_W-1:0] hp_q;
    logic [HP_W-1:0] hp_d;
    phase_t          phase_q;
    phase_t          phase_d;

    // Next half-period count and phase.
    always_comb begin
        hp_d    = hp_q;
        phase_d = phase_q;
        if (hp_q == HP_LAST) begin
            hp_d    = '0;
            phase_d = (phase_q == POS) ? NEG : POS;
        end else begin
            hp_d    = hp_q + HP_W'(1);
            phase_d = phase_q;
        end
    end

    // Oscillator state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hp_q    <= '0;
            phase_q <= POS;
        end else begin
            hp_q    <= hp_d;
            phase_q <= phase_d;
        end
    end

    assign sample_o = (phase_q == POS) ? AMP_POS : AMP_NEG;

endmodule

// File: rtl/play_audio.sv
// Pac-Man chomp tone generator feeding the audio codec sample path.
// Optional build macro EATGHOST_TONE_EN adds a higher-priority eat-ghost tone.
module play_audio
    import play_audio_pkg::*;
#(
    parameter int DATA_W            = DEF_DATA_W,
    parameter int WINDOW            = DEF_WINDOW,
    parameter int HALF_PERIOD       = DEF_HALF_PERIOD,
    parameter int AMPLITUDE         = DEF_AMPLITUDE,
    parameter int GHOST_HALF_PERIOD = DEF_GHOST_HALF_PERIOD
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     chomp,
    input  logic                     eatghost,
    input  logic                     write_ready,
    output logic                     write,
    output logic signed [DATA_W-1:0] writedata_left,
    output logic signed [DATA_W-1:0] writedata_right
);

    localparam int REM_W = $clog2(WINDOW + 1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(WINDOW);

    logic [REM_W-1:0]         remain_q;
    logic [REM_W-1:0]         remain_d;
    logic                     active_s;
    logic signed [DATA_W-1:0] chomp_sample_s;
    logic signed [DATA_W-1:0] sample_s;

    // Chomp window: a trigger reloads the full window, otherwise count down to zero.
    always_comb begin
        remain_d = remain_q;
        if (chomp) begin
            remain_d = REM_FULL;
        end else if (remain_q != '0) begin
            remain_d = remain_q - REM_W'(1);
        end else begin
            remain_d = remain_q;
        end
    end

    // Chomp window register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign active_s = (remain_q != '0);

    tone_osc #(
        .DATA_W      (DATA_W),
        .HALF_PERIOD (HALF_PERIOD),
        .AMPLITUDE   (AMPLITUDE)
    ) u_chomp_osc (
        .clk      (CLOCK_50),
        .reset    (reset),
        .sample_o (chomp_sample_s)
    );

`ifdef EATGHOST_TONE_EN
    logic [REM_W-1:0]         g_remain_q;
    logic [REM_W-1:0]         g_remain_d;
    logic                     g_active_s;
    logic signed [DATA_W-1:0] ghost_sample_s;

    // Eat-ghost window follows the same reload/count-down rules as the chomp window.
    always_comb begin
        g_remain_d = g_remain_q;
        if (eatghost) begin
            g_remain_d = REM_FULL;
        end else if (g_remain_q != '0) begin
            g_remain_d = g_remain_q - REM_W'(1);
        end else begin
            g_remain_d = g_remain_q;
        end
    end

    // Eat-ghost window register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            g_remain_q <= '0;
        end else begin
            g_remain_q <= g_remain_d;
        end
    end

    assign g_active_s = (g_remain_q != '0);

    tone_osc #(
        .DATA_W      (DATA_W),
        .HALF_PERIOD (GHOST_HALF_PERIOD),
        .AMPLITUDE   (AMPLITUDE)
    ) u_ghost_osc (
        .clk      (CLOCK_50),
        .reset    (reset),
        .sample_o (ghost_sample_s)
    );

    // Ghost tone wins; otherwise chomp tone while its window is open.
    always_comb begin
        sample_s = '0;
        if (g_active_s) begin
            sample_s = ghost_sample_s;
        end else if (active_s) begin
            sample_s = chomp_sample_s;
        end else begin
            sample_s = '0;
        end
    end
`else
    logic unused_eatghost_s;
    assign unused_eatghost_s = eatghost;

    // Chomp tone while its window is open, silence otherwise.
    always_comb begin
        sample_s = '0;
        if (active_s) begin
            sample_s = chomp_sample_s;
        end else begin
            sample_s = '0;
        end
    end
`endif

    assign writedata_left  = sample_s;
    assign writedata_right = sample_s;
    assign write           = write_ready;

endmodule

// File: tb/tb_play_audio.sv
// Randomized and directed bench for play_audio against an edge-counting reference model.
module tb_play_audio;

    localparam int DATA_W  = 24;
    localparam int WINDOW  = 20;
    localparam int HP      = 5;
    localparam int AMP     = 4000000;
    localparam int GHP     = 2;

    logic                     CLOCK_50 = 1'b0;
    logic                     reset;
    logic                     chomp;
    logic                     eatghost;
    logic                     write_ready;
    logic                     write;
    logic signed [DATA_W-1:0] writedata_left;
    logic signed [DATA_W-1:0] writedata_right;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Reference model: edges since reset, and edge index of the latest triggers.
    int n          = 0;
    int last_chomp = -1;
    int last_ghost = -1;

    play_audio #(
        .DATA_W            (DATA_W),
        .WINDOW            (WINDOW),
        .HALF_PERIOD       (HP),
        .AMPLITUDE         (AMP),
        .GHOST_HALF_PERIOD (GHP)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .chomp           (chomp),
        .eatghost        (eatghost),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input longint got, input longint exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic longint square(input int edges, input int half);
        return (((edges / half) % 2) == 0) ? longint'(AMP) : -longint'(AMP);
    endfunction

    function automatic longint expected_sample();
        longint s;
        s = 0;
        if (last_chomp >= 0 && (n - last_chomp) < WINDOW)
            s = square(n, HP);
`ifdef EATGHOST_TONE_EN
        if (last_ghost >= 0 && (n - last_ghost) < WINDOW)
            s = square(n, GHP);
`endif
        return s;
    endfunction

    // Drive one cycle from the falling edge, advance the model at the rising edge,
    // and compare on the following falling edge.
    task automatic step(input logic r, input logic c, input logic g, input logic wr);
        reset       = r;
        chomp       = c;
        eatghost    = g;
        write_ready = wr;
        @(posedge CLOCK_50);
        if (r) begin
            n          = 0;
            last_chomp = -1;
            last_ghost = -1;
        end else begin
            n++;
            if (c) last_chomp = n;
            if (g) last_ghost = n;
        end
        @(negedge CLOCK_50);
        check_val("left",  longint'(writedata_left),  expected_sample());
        check_val("right", longint'(writedata_right), expected_sample());
        check_val("write", longint'(write), longint'(wr));
        check_val("phase", longint'(dut.u_chomp_osc.phase_q), longint'((n / HP) % 2));
        check_val("hp",    longint'(dut.u_chomp_osc.hp_q),    longint'(n % HP));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        chomp       = 1'b0;
        eatghost    = 1'b0;
        write_ready = 1'b1;
        @(negedge CLOCK_50);

        // Reset, then a silent free-running stretch.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(30);

        // Single pulse.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(25);

        // Retrigger 12 cycles after the first pulse.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(11);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(25);

        // Chomp held high.
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(25);

        // Reset in the middle of a window.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // write_ready toggling during an active window.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b0, logic'(i % 2));

        // Eat-ghost during an open chomp window (ignored without the feature).
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(30);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(25);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 79) == 0),
                 logic'($urandom_range(0, 11) == 0),
                 logic'($urandom_range(0, 17) == 0),
                 logic'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
